word_count_reducer: RTL and testbench

WORD_COUNT_REDUCER -- requirements
Module: word_count_reducer

---
 rtl/word_count_reducer.sv | 171 +++++++++++++++++
 tb/tb_word_count_reducer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/word_count_reducer.sv
// Word-count reducer: accumulates {count,key} mapper records in a small table, spilling or flushing it downstream.
// Optional build macro WORD_COUNT_REDUCER_SAT_EN makes count accumulation saturate instead of wrapping.
module word_count_reducer #(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] io_rx_dat_int,
    input  logic        io_rx_val,
    input  logic        io_rx_last,
    output logic        io_rx_rdy,
    output logic [63:0] io_tx_dat_int,
    output logic        io_tx_val,
    input  logic        io_tx_rdy,
    output logic        io_tx_last
);
    localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {ACCUM, SPILL, INSERT, FLUSH} state_t;

    state_t               r_state, w_state_nxt;
    logic [ENTRIES-1:0]   r_valid;
    logic [55:0]          r_key [ENTRIES];
    logic [CNT_W-1:0]     r_cnt [ENTRIES];
    logic                 r_pend_valid, r_pend_last;
    logic [55:0]          r_pend_key;
    logic [4:0]           r_pend_cnt;
    logic                 r_tx_val, r_tx_last;
    logic [63:0]          r_tx_dat;

    logic                 w_accept, w_hit, w_free, w_to_flush, w_slot_free;
    logic                 w_emit, w_found, w_more;
    logic [IDX_W-1:0]     w_hit_idx, w_free_idx, w_emit_idx;
    logic [55:0]          w_rec_key;
    logic [4:0]           w_rec_cnt;
    logic [SUM_W-1:0]     w_sum;
    logic [CNT_W-1:0]     w_hit_cnt;
    logic [ENTRIES-1:0]   w_valid_n, w_rest;
    logic [55:0]          w_key_n [ENTRIES];
    logic [CNT_W-1:0]     w_cnt_n [ENTRIES];
    logic                 w_unused;

    assign w_unused    = ^io_rx_dat_int[63:61];
    assign w_rec_key   = io_rx_dat_int[55:0];
    assign w_rec_cnt   = io_rx_dat_int[60:56];
    assign w_accept    = io_rx_val && io_rx_rdy;
    assign w_slot_free = !r_tx_val || io_tx_rdy;

    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!w_hit && r_valid[i] && (r_key[i] == w_rec_key)) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
            if (!w_free && !r_valid[i]) begin
                w_free     = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_sum = {1'b0, r_cnt[w_hit_idx]} + SUM_W'(w_rec_cnt);
`ifdef WORD_COUNT_REDUCER_SAT_EN
        w_hit_cnt = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
`else
        w_hit_cnt = w_sum[CNT_W-1:0];
`endif
    end

    // Emission looks at the post-update table so a flush can present its first record
    // in the cycle right after the accepting/insert edge.
    always_comb begin
        w_valid_n = r_valid;
        w_key_n   = r_key;
        w_cnt_n   = r_cnt;
        if (w_accept && w_hit) begin
            w_cnt_n[w_hit_idx] = w_hit_cnt;
        end else if (w_accept && w_free) begin
            w_valid_n[w_free_idx] = 1'b1;
            w_key_n[w_free_idx]   = w_rec_key;
            w_cnt_n[w_free_idx]   = CNT_W'(w_rec_cnt);
        end
        if (r_state == INSERT) begin
            w_valid_n[0] = 1'b1;
            w_key_n[0]   = r_pend_key;
            w_cnt_n[0]   = CNT_W'(r_pend_cnt);
        end
        w_to_flush = (w_accept && io_rx_last && (w_hit || w_free)) ||
                     ((r_state == INSERT) && r_pend_last);
        w_found    = 1'b0;
        w_emit_idx = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!w_found && w_valid_n[i]) begin
                w_found    = 1'b1;
                w_emit_idx = IDX_W'(i);
            end
        end
        w_rest = w_valid_n;
        w_rest[w_emit_idx] = 1'b0;
        w_more = |w_rest;
        w_emit = ((r_state == SPILL) || (r_state == FLUSH) || w_to_flush) && w_slot_free && w_found;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ACCUM;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM:  if (w_accept) w_state_nxt = (w_hit || w_free) ? (io_rx_last ? FLUSH : ACCUM) : SPILL;
            SPILL:  if (w_slot_free && !w_found) w_state_nxt = INSERT;
            INSERT: w_state_nxt = r_pend_last ? FLUSH : ACCUM;
            FLUSH:  if (w_slot_free && !w_found) w_state_nxt = ACCUM;
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        io_rx_rdy     = (r_state == ACCUM) && !r_pend_valid;
        io_tx_val     = r_tx_val;
        io_tx_dat_int = r_tx_dat;
        io_tx_last    = r_tx_last;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid      <= '0;
            r_pend_valid <= 1'b0;
            r_pend_last  <= 1'b0;
            r_pend_key   <= '0;
            r_pend_cnt   <= '0;
            r_tx_val     <= 1'b0;
            r_tx_last    <= 1'b0;
            r_tx_dat     <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_key[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            r_valid <= w_emit ? w_rest : w_valid_n;
            r_key   <= w_key_n;
            r_cnt   <= w_cnt_n;
            if (w_accept && !w_hit && !w_free) begin
                r_pend_valid <= 1'b1;
                r_pend_last  <= io_rx_last;
                r_pend_key   <= w_rec_key;
                r_pend_cnt   <= w_rec_cnt;
            end else if (r_state == INSERT) begin
                r_pend_valid <= 1'b0;
                r_pend_last  <= 1'b0;
            end
            if (w_emit) begin
                r_tx_val  <= 1'b1;
                r_tx_dat  <= {8'(w_cnt_n[w_emit_idx]), w_key_n[w_emit_idx]};
                r_tx_last <= (r_state != SPILL) && !w_more;
            end else if (w_slot_free) begin
                r_tx_val  <= 1'b0;
                r_tx_last <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_word_count_reducer.sv
// Directed self-checking bench for word_count_reducer: table-driven record streams plus stall and reset sequences.
module tb_word_count_reducer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] io_rx_dat_int = '0;
    logic        io_rx_val = 1'b0;
    logic        io_rx_last = 1'b0;
    logic        io_rx_rdy;
    logic [63:0] io_tx_dat_int;
    logic        io_tx_val;
    logic        io_tx_rdy = 1'b1;
    logic        io_tx_last;

    always #5 clk = ~clk;

    word_count_reducer #(.ENTRIES(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .io_rx_dat_int(io_rx_dat_int), .io_rx_val(io_rx_val), .io_rx_last(io_rx_last), .io_rx_rdy(io_rx_rdy),
        .io_tx_dat_int(io_tx_dat_int), .io_tx_val(io_tx_val), .io_tx_rdy(io_tx_rdy), .io_tx_last(io_tx_last)
    );

    typedef struct { logic [55:0] key; logic [4:0] cnt; logic last; } vec_t;
    typedef struct { logic [63:0] dat; logic last; } exp_t;

    vec_t        vin[$];
    exp_t        vexp[$];
    logic [64:0] mon_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          stall_err = 0;
    logic        prev_stall = 1'b0;
    logic [64:0] prev_out = '0;

    localparam logic [55:0] KA = 56'h41_0000_0000_00AA;
    localparam logic [55:0] KB = 56'h42_0000_0000_00BB;
    localparam logic [55:0] KC = 56'h43_0000_0000_00CC;
    localparam logic [55:0] KD = 56'h44_0000_0000_00DD;

    function automatic logic [55:0] kk(input int i);
        return 56'h5A_1234_0000_0000 + 56'(i);
    endfunction

    // Handshakes complete at posedge; both sides are stable at the preceding negedge.
    always @(negedge clk) begin
        if (reset && io_tx_val && io_tx_rdy) mon_q.push_back({io_tx_last, io_tx_dat_int});
        if (prev_stall && (io_tx_val !== 1'b1 || {io_tx_last, io_tx_dat_int} !== prev_out))
            stall_err <= stall_err + 1;
        prev_stall <= reset && io_tx_val && !io_tx_rdy;
        prev_out   <= {io_tx_last, io_tx_dat_int};
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic void add_in(input logic [55:0] k, input logic [4:0] c, input logic l);
        vin.push_back('{key: k, cnt: c, last: l});
    endfunction

    function automatic void add_exp(input logic [7:0] c, input logic [55:0] k, input logic l);
        vexp.push_back('{dat: {c, k}, last: l});
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [55:0] k, input logic [4:0] c, input logic l);
        int n = 0;
        io_rx_dat_int = {3'b101, c, k};
        io_rx_last    = l;
        io_rx_val     = 1'b1;
        @(negedge clk);
        while (!io_rx_rdy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("rx_rdy_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        io_rx_val  = 1'b0;
        io_rx_last = 1'b0;
    endtask

    task automatic send_all(output int low_cycles);
        low_cycles = 0;
        foreach (vin[i]) send(vin[i].key, vin[i].cnt, vin[i].last);
        @(negedge clk);
        while (!io_rx_rdy && low_cycles < 1000) begin
            low_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic compare_outputs(input string name);
        int          c = 0;
        logic [64:0] got;
        while (mon_q.size() < vexp.size() && c < 3000) begin
            @(negedge clk);
            c++;
        end
        repeat (12) @(negedge clk);
        check({name, ".count"}, 64'(mon_q.size()), 64'(vexp.size()));
        for (int i = 0; i < vexp.size(); i++) begin
            got = (i < mon_q.size()) ? mon_q[i] : '1;
            check($sformatf("%s[%0d].dat", name, i), got[63:0], vexp[i].dat);
            check($sformatf("%s[%0d].last", name, i), 64'(got[64]), 64'(vexp[i].last));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          low;
        logic [64:0] first;
        repeat (3) @(posedge clk);
        #1;
        check("rst.tx_val", 64'(io_tx_val), 64'd0);
        check("rst.tx_last", 64'(io_tx_last), 64'd0);
        check("rst.tx_dat", io_tx_dat_int, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst.rx_rdy", 64'(io_rx_rdy), 64'd1);

        // A,B,A,A with last on the fourth record
        vin.delete(); vexp.delete(); mon_q.delete();
        add_in(KA, 5'd1, 1'b0); add_in(KB, 5'd1, 1'b0); add_in(KA, 5'd1, 1'b0); add_in(KA, 5'd1, 1'b1);
        add_exp(8'd3, KA, 1'b0); add_exp(8'd1, KB, 1'b1);
        send_all(low);
        check("abaa.rx_rdy_low_cycles", 64'(low), 64'd2);
        check("abaa.tx_val_idle", 64'(io_tx_val), 64'd0);
        compare_outputs("abaa");

        // mixed counts, accumulation above the 5-bit record width
        vin.delete(); vexp.delete(); mon_q.delete();
        add_in(KC, 5'd31, 1'b0); add_in(KD, 5'd5, 1'b0); add_in(KC, 5'd31, 1'b1);
        add_exp(8'd62, KC, 1'b0); add_exp(8'd5, KD, 1'b1);
        send_all(low);
        compare_outputs("mixed");

        // nine distinct keys, last on the ninth: spill then single-entry flush
        vin.delete(); vexp.delete(); mon_q.delete();
        for (int i = 0; i < 9; i++) add_in(kk(i), 5'd1, i == 8);
        for (int i = 0; i < 8; i++) add_exp(8'd1, kk(i), 1'b0);
        add_exp(8'd1, kk(8), 1'b1);
        send_all(low);
        compare_outputs("spill_last");

        // spill without last; inserted key then accumulates before a later flush
        vin.delete(); vexp.delete(); mon_q.delete();
        for (int i = 0; i < 9; i++) add_in(kk(i + 20), 5'd1, 1'b0);
        add_in(kk(28), 5'd2, 1'b1);
        for (int i = 0; i < 8; i++) add_exp(8'd1, kk(i + 20), 1'b0);
        add_exp(8'd3, kk(28), 1'b1);
        send_all(low);
        compare_outputs("spill_insert");

        // 260 unit records: wrap or saturate at 8 bits
        vin.delete(); vexp.delete(); mon_q.delete();
        for (int i = 0; i < 260; i++) add_in(KA, 5'd1, i == 259);
`ifdef WORD_COUNT_REDUCER_SAT_EN
        add_exp(8'd255, KA, 1'b1);
`else
        add_exp(8'd4, KA, 1'b1);
`endif
        send_all(low);
        compare_outputs("count260");

        // flush under a toggling downstream ready
        vin.delete(); vexp.delete(); mon_q.delete();
        add_in(KB, 5'd2, 1'b0); add_in(KC, 5'd3, 1'b0); add_in(KD, 5'd4, 1'b1);
        add_exp(8'd2, KB, 1'b0); add_exp(8'd3, KC, 1'b0); add_exp(8'd4, KD, 1'b1);
        io_tx_rdy = 1'b0;
        foreach (vin[i]) send(vin[i].key, vin[i].cnt, vin[i].last);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            io_tx_rdy = ~io_tx_rdy;
            @(posedge clk);
            #1;
        end
        io_tx_rdy = 1'b1;
        compare_outputs("stall");
        check("stall.hold_violations", 64'(stall_err), 64'd0);

        // reset in the middle of a four-entry flush
        vin.delete(); vexp.delete(); mon_q.delete();
        for (int i = 0; i < 4; i++) send(kk(i + 40), 5'd1, i == 3);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst.tx_val", 64'(io_tx_val), 64'd0);
        check("midrst.tx_last", 64'(io_tx_last), 64'd0);
        check("midrst.tx_dat", io_tx_dat_int, 64'd0);
        check("midrst.count", 64'(mon_q.size()), 64'd1);
        first = (mon_q.size() > 0) ? mon_q[0] : '1;
        check("midrst.first", first[63:0], {8'd1, kk(40)});
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("postrst.rx_rdy", 64'(io_rx_rdy), 64'd1);
        mon_q.delete();
        add_in(KC, 5'd1, 1'b1);
        add_exp(8'd1, KC, 1'b1);
        send_all(low);
        compare_outputs("postrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end
endmodule
